// File: rtl/vm2002_credit_mgr.sv
// Coin/credit stage of vm2002: accumulates coin credit, settles vend requests against a
// price, and pays change (or cancelled credit) back to the hopper one coin at a time.
module vm2002_credit_mgr #(
   parameter int CREDIT_W   = 8,
   parameter int MAX_CREDIT = 40
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                coin_valid,
   input  logic [1:0]          coin,
   output logic                coin_accept,
   output logic                coin_reject,
   output logic [CREDIT_W-1:0] credit,
   input  logic                vend_req,
   input  logic [CREDIT_W-1:0] vend_price,
   output logic                vend_ack,
   output logic                vend_nack,
   input  logic                cancel,
   output logic                change_valid,
   output logic [1:0]          change_coin,
   input  logic                change_ready,
   output logic                busy
);

   // state     | meaning
   // ST_IDLE   | taking coins, vend requests and cancel
   // ST_CHANGE | paying out remainder to the hopper; new requests refused
   typedef enum logic {ST_IDLE, ST_CHANGE} state_t;

   localparam logic [1:0] COIN_NICKEL  = 2'd0;
   localparam logic [1:0] COIN_DIME    = 2'd1;
   localparam logic [1:0] COIN_QUARTER = 2'd2;

   function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] c);
      case (c)
         COIN_NICKEL:  coin_value = CREDIT_W'(1);
         COIN_DIME:    coin_value = CREDIT_W'(2);
         COIN_QUARTER: coin_value = CREDIT_W'(5);
         default:      coin_value = '0;
      endcase
   endfunction

   function automatic logic [1:0] greedy_coin(input logic [CREDIT_W-1:0] r);
      if (r >= CREDIT_W'(5))      greedy_coin = COIN_QUARTER;
      else if (r >= CREDIT_W'(2)) greedy_coin = COIN_DIME;
      else                        greedy_coin = COIN_NICKEL;
   endfunction

   state_t              state_q, state_d;
   logic [CREDIT_W-1:0] credit_q, credit_d;
   logic [CREDIT_W-1:0] rem_q, rem_d;
   logic                coin_accept_q, coin_accept_d;
   logic                coin_reject_q, coin_reject_d;
   logic                vend_ack_q, vend_ack_d;
   logic                vend_nack_q, vend_nack_d;
   logic                change_valid_q, change_valid_d;
   logic [1:0]          change_coin_q, change_coin_d;
   logic                busy_q, busy_d;

   logic [CREDIT_W:0]   coin_sum;
   logic                coin_legal;
   logic [CREDIT_W-1:0] vend_rem;
   logic [CREDIT_W-1:0] rem_after;

   always_comb begin
      state_d        = state_q;
      credit_d       = credit_q;
      rem_d          = rem_q;
      coin_accept_d  = 1'b0;
      coin_reject_d  = 1'b0;
      vend_ack_d     = 1'b0;
      vend_nack_d    = 1'b0;
      change_valid_d = change_valid_q;
      change_coin_d  = change_coin_q;

      // Widened by one bit so an overflowing coin is caught rather than wrapped.
      coin_sum   = {1'b0, credit_q} + {1'b0, coin_value(coin)};
      coin_legal = (coin != 2'd3);
      vend_rem   = credit_q - vend_price;
      rem_after  = rem_q - coin_value(change_coin_q);

      case (state_q)
         ST_IDLE: begin
            if (cancel) begin
               rem_d         = credit_q;
               credit_d      = '0;
               coin_reject_d = coin_valid;
               if (credit_q != '0) begin
                  state_d        = ST_CHANGE;
                  change_valid_d = 1'b1;
                  change_coin_d  = greedy_coin(credit_q);
               end
            end else if (vend_req) begin
               coin_reject_d = coin_valid;
               if (vend_price <= credit_q) begin
                  vend_ack_d = 1'b1;
                  rem_d      = vend_rem;
                  credit_d   = '0;
                  if (vend_rem != '0) begin
                     state_d        = ST_CHANGE;
                     change_valid_d = 1'b1;
                     change_coin_d  = greedy_coin(vend_rem);
                  end
               end else begin
                  vend_nack_d = 1'b1;
               end
            end else if (coin_valid) begin
               if (coin_legal && coin_sum <= (CREDIT_W+1)'(MAX_CREDIT)) begin
                  credit_d      = coin_sum[CREDIT_W-1:0];
                  coin_accept_d = 1'b1;
               end else begin
                  coin_reject_d = 1'b1;
               end
            end
         end
         ST_CHANGE: begin
            coin_reject_d = coin_valid;
            vend_nack_d   = vend_req;
            if (change_valid_q && change_ready) begin
               rem_d = rem_after;
               if (rem_after == '0) begin
                  state_d        = ST_IDLE;
                  change_valid_d = 1'b0;
                  change_coin_d  = COIN_NICKEL;
               end else begin
                  change_coin_d = greedy_coin(rem_after);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d == ST_CHANGE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         credit_q       <= '0;
         rem_q          <= '0;
         coin_accept_q  <= 1'b0;
         coin_reject_q  <= 1'b0;
         vend_ack_q     <= 1'b0;
         vend_nack_q    <= 1'b0;
         change_valid_q <= 1'b0;
         change_coin_q  <= COIN_NICKEL;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         credit_q       <= credit_d;
         rem_q          <= rem_d;
         coin_accept_q  <= coin_accept_d;
         coin_reject_q  <= coin_reject_d;
         vend_ack_q     <= vend_ack_d;
         vend_nack_q    <= vend_nack_d;
         change_valid_q <= change_valid_d;
         change_coin_q  <= change_coin_d;
         busy_q         <= busy_d;
      end
   end

   assign coin_accept  = coin_accept_q;
   assign coin_reject  = coin_reject_q;
   assign credit       = credit_q;
   assign vend_ack     = vend_ack_q;
   assign vend_nack    = vend_nack_q;
   assign change_valid = change_valid_q;
   assign change_coin  = change_coin_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_vm2002_credit_mgr.sv
// Directed bench for vm2002_credit_mgr: table of per-cycle vectors plus hand sequences
// for reset during change and a full payout with the hopper always ready.
module tb_vm2002_credit_mgr;

   localparam logic [1:0] N = 2'd0, D = 2'd1, Q = 2'd2, I = 2'd3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       coin_valid = 1'b0;
   logic [1:0] coin = N;
   logic       coin_accept, coin_reject;
   logic [7:0] credit;
   logic       vend_req = 1'b0;
   logic [7:0] vend_price = '0;
   logic       vend_ack, vend_nack;
   logic       cancel = 1'b0;
   logic       change_valid;
   logic [1:0] change_coin;
   logic       change_ready = 1'b0;
   logic       busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   vm2002_credit_mgr #(.CREDIT_W(8), .MAX_CREDIT(40)) dut (
      .clk(clk), .rst_n(rst_n),
      .coin_valid(coin_valid), .coin(coin),
      .coin_accept(coin_accept), .coin_reject(coin_reject), .credit(credit),
      .vend_req(vend_req), .vend_price(vend_price),
      .vend_ack(vend_ack), .vend_nack(vend_nack),
      .cancel(cancel),
      .change_valid(change_valid), .change_coin(change_coin), .change_ready(change_ready),
      .busy(busy)
   );

   typedef struct {
      logic       cv;
      logic [1:0] coin;
      logic       vr;
      logic [7:0] price;
      logic       can;
      logic       rdy;
      logic [14:0] exp;  // {acc,rej,ack,nack,credit[7:0],chv,chc[1:0],busy}
   } vec_t;

   vec_t vecs[$];

   function automatic logic [14:0] outs();
      return {coin_accept, coin_reject, vend_ack, vend_nack, credit,
              change_valid, change_coin, busy};
   endfunction

   task automatic add(input logic cv, input logic [1:0] c, input logic vr,
                      input logic [7:0] price, input logic can, input logic rdy,
                      input logic acc, input logic rej, input logic ack, input logic nack,
                      input logic [7:0] cr, input logic chv, input logic [1:0] chc,
                      input logic bsy);
      vec_t v;
      v.cv = cv; v.coin = c; v.vr = vr; v.price = price; v.can = can; v.rdy = rdy;
      v.exp = {acc, rej, ack, nack, cr, chv, chc, bsy};
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got={acc,rej,ack,nack,credit,chv,chc,busy}=%b_%0d_%b_%b want=%b_%0d_%b_%b",
                  name, act[14:11], act[10:3], act[2], act[0],
                  exp[14:11], exp[10:3], exp[2], exp[0]);
      end
   endtask

   task automatic apply(input vec_t v, input string name);
      @(negedge clk);
      coin_valid = v.cv; coin = v.coin; vend_req = v.vr; vend_price = v.price;
      cancel = v.can; change_ready = v.rdy;
      @(posedge clk);
      #1;
      check(name, outs(), v.exp);
   endtask

   task automatic idle_inputs();
      @(negedge clk);
      coin_valid = 0; coin = N; vend_req = 0; vend_price = 0; cancel = 0; change_ready = 0;
   endtask

   initial begin
      vec_t v;
      logic [1:0] got[$];
      int cyc;

      // T1: Q,Q,D then vend 10 -> DIME change
      add(1,Q,0,0,0,0, 1,0,0,0, 5,0,N,0);
      add(1,Q,0,0,0,0, 1,0,0,0, 10,0,N,0);
      add(1,D,0,0,0,0, 1,0,0,0, 12,0,N,0);
      add(0,N,1,10,0,0, 0,0,1,0, 0,1,D,1);
      add(0,N,0,0,0,1, 0,0,0,0, 0,0,N,0);
      // T2: illegal coin at credit 3, then cancel pays D,N
      add(1,N,0,0,0,0, 1,0,0,0, 1,0,N,0);
      add(1,D,0,0,0,0, 1,0,0,0, 3,0,N,0);
      add(1,I,0,0,0,0, 0,1,0,0, 3,0,N,0);
      add(0,N,0,0,1,0, 0,0,0,0, 0,1,D,1);
      add(0,N,0,0,0,1, 0,0,0,0, 0,1,N,1);
      add(0,N,0,0,0,1, 0,0,0,0, 0,0,N,0);
      // T3: fill to 38, overflow boundary around MAX_CREDIT=40
      for (int i = 1; i <= 7; i++) add(1,Q,0,0,0,0, 1,0,0,0, 8'(5*i),0,N,0);
      add(1,D,0,0,0,0, 1,0,0,0, 37,0,N,0);
      add(1,N,0,0,0,0, 1,0,0,0, 38,0,N,0);
      add(1,Q,0,0,0,0, 0,1,0,0, 38,0,N,0);
      add(1,N,0,0,0,0, 1,0,0,0, 39,0,N,0);
      add(1,D,0,0,0,0, 0,1,0,0, 39,0,N,0);
      add(1,N,0,0,0,0, 1,0,0,0, 40,0,N,0);
      add(1,N,0,0,0,0, 0,1,0,0, 40,0,N,0);
      add(0,N,1,40,0,0, 0,0,1,0, 0,0,N,0);
      // T4: price above / equal to credit
      add(1,Q,0,0,0,0, 1,0,0,0, 5,0,N,0);
      add(0,N,1,6,0,0, 0,0,0,1, 5,0,N,0);
      add(0,N,1,5,0,0, 0,0,1,0, 0,0,N,0);
      // T5: credit 8, cancel, hopper stalls 3 cycles, requests refused while busy
      add(1,Q,0,0,0,0, 1,0,0,0, 5,0,N,0);
      add(1,D,0,0,0,0, 1,0,0,0, 7,0,N,0);
      add(1,N,0,0,0,0, 1,0,0,0, 8,0,N,0);
      add(0,N,0,0,1,0, 0,0,0,0, 0,1,Q,1);
      add(0,N,0,0,1,0, 0,0,0,0, 0,1,Q,1);
      add(1,N,0,0,0,0, 0,1,0,0, 0,1,Q,1);
      add(0,N,1,3,0,0, 0,0,0,1, 0,1,Q,1);
      add(0,N,0,0,0,1, 0,0,0,0, 0,1,D,1);
      add(0,N,0,0,0,1, 0,0,0,0, 0,1,N,1);
      add(0,N,0,0,0,1, 0,0,0,0, 0,0,N,0);
      // zero price: at zero credit, then with credit 1 (full credit returned)
      add(0,N,1,0,0,0, 0,0,1,0, 0,0,N,0);
      add(1,N,0,0,0,0, 1,0,0,0, 1,0,N,0);
      add(0,N,1,0,0,0, 0,0,1,0, 0,1,N,1);
      add(0,N,0,0,0,1, 0,0,0,0, 0,0,N,0);
      // cancel+vend+coin together: only cancel acts, coin rejected
      add(1,D,0,0,0,0, 1,0,0,0, 2,0,N,0);
      add(1,N,1,1,1,0, 0,1,0,0, 0,1,D,1);
      add(0,N,0,0,0,1, 0,0,0,0, 0,0,N,0);
      // cancel with nothing held: no pulse, stays idle
      add(0,N,0,0,1,0, 0,0,0,0, 0,0,N,0);

      #3;
      check("reset_state", outs(), 15'b0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

      // T6: reset asserted mid-CHANGE with remainder 7
      v.vr = 0; v.price = 0; v.can = 0; v.rdy = 0; v.cv = 1;
      v.coin = Q; v.exp = {4'b1000, 8'd5, 1'b0, N, 1'b0}; apply(v, "t6_q");
      v.coin = D; v.exp = {4'b1000, 8'd7, 1'b0, N, 1'b0}; apply(v, "t6_d");
      v.cv = 0; v.can = 1; v.exp = {4'b0000, 8'd0, 1'b1, Q, 1'b1}; apply(v, "t6_cancel");
      v.can = 0; v.exp = {4'b0000, 8'd0, 1'b1, Q, 1'b1}; apply(v, "t6_hold");
      #2;
      rst_n = 1'b0;
      #1;
      check("t6_async_reset", outs(), 15'b0);
      @(negedge clk);
      rst_n = 1'b1;
      v.rdy = 1; v.exp = 15'b0; apply(v, "t6_no_payout");
      v.rdy = 0; v.cv = 1; v.coin = N; v.exp = {4'b1000, 8'd1, 1'b0, N, 1'b0};
      apply(v, "t6_idle_accept");

      // Full payout of 9 nickels with hopper always ready: expect Q, D, D
      v.cv = 1; v.coin = Q; v.exp = {4'b1000, 8'd6, 1'b0, N, 1'b0}; apply(v, "pay_q");
      v.coin = D; v.exp = {4'b1000, 8'd8, 1'b0, N, 1'b0}; apply(v, "pay_d");
      v.coin = N; v.exp = {4'b1000, 8'd9, 1'b0, N, 1'b0}; apply(v, "pay_n");
      v.cv = 0; v.can = 1; v.exp = {4'b0000, 8'd0, 1'b1, Q, 1'b1}; apply(v, "pay_cancel");
      idle_inputs();
      change_ready = 1'b1;
      cyc = 0;
      while (change_valid && cyc < 10) begin
         got.push_back(change_coin);
         cyc++;
         @(negedge clk);
      end
      total++;
      if (change_valid) begin
         bad++;
         $display("FAIL pay_timeout got=change_valid still high after %0d cycles want=drop", cyc);
      end
      total++;
      if (got.size() != 3 || got[0] !== Q || got[1] !== D || got[2] !== D) begin
         bad++;
         $display("FAIL pay_sequence got=%0d coins (%p) want=3 coins Q,D,D", got.size(), got);
      end
      total++;
      if (busy !== 1'b0 || credit !== 8'd0) begin
         bad++;
         $display("FAIL pay_end got=busy%b credit%0d want=busy0 credit0", busy, credit);
      end
      change_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
